// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter with an Avalon-MM slave for byte
// launch, status and interrupt control; open-drain lines via *_oe outputs.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 32'd5000,
  parameter int unsigned RTS_CYCLES     = 32'd16,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic       csi_clk,
  input  logic       csi_reset,
  input  logic       avs_s1_address,
  input  logic       avs_s1_read,
  output logic [7:0] avs_s1_readdata,
  input  logic       avs_s1_write,
  input  logic [7:0] avs_s1_writedata,
  output logic       ins_irq0_irq,
  input  logic       coe_kc_in,
  input  logic       coe_kd_in,
  output logic       coe_kc_oe,
  output logic       coe_kd_oe
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  function automatic logic odd_parity(input logic [7:0] value);
    return ~^value;
  endfunction

  state_t      state_r, state_s;
  logic        kc_meta_r, kc_sync_r, kc_prev_r;
  logic        kd_meta_r, kd_sync_r;
  logic        kc_fall_s;
  logic [7:0]  byte_r, byte_s;
  logic        ack_err_r, ack_err_s;
  logic        timeout_r, timeout_s;
  logic [31:0] cnt_r, cnt_s;
  logic [31:0] tcnt_r, tcnt_s;
  logic [3:0]  bit_cnt_r, bit_cnt_s;
  logic        kc_oe_s, kd_oe_s;
  logic        irq_s;
  logic        done_s;
  logic        busy_s;
  logic        host_wr_s;
  logic        ctrl_wr_s;

  assign kc_fall_s = kc_prev_r & ~kc_sync_r;
  assign busy_s    = (state_r != IDLE);
  assign host_wr_s = avs_s1_write & (avs_s1_address == 1'b0);
  assign ctrl_wr_s = avs_s1_write & (avs_s1_address == 1'b1);

  // Two-flop synchronizers for the asynchronous PS/2 lines plus kc history.
  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      kc_meta_r <= 1'b1;
      kc_sync_r <= 1'b1;
      kc_prev_r <= 1'b1;
      kd_meta_r <= 1'b1;
      kd_sync_r <= 1'b1;
    end else begin
      kc_meta_r <= coe_kc_in;
      kc_sync_r <= kc_meta_r;
      kc_prev_r <= kc_sync_r;
      kd_meta_r <= coe_kd_in;
      kd_sync_r <= kd_meta_r;
    end
  end

  // State register.
  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and next values of every datapath register.
  always_comb begin
    state_s   = state_r;
    kc_oe_s   = coe_kc_oe;
    kd_oe_s   = coe_kd_oe;
    byte_s    = byte_r;
    ack_err_s = ack_err_r;
    timeout_s = timeout_r;
    cnt_s     = cnt_r;
    tcnt_s    = tcnt_r;
    bit_cnt_s = bit_cnt_r;
    done_s    = 1'b0;

    case (state_r)
      IDLE: begin
        kc_oe_s = 1'b0;
        kd_oe_s = 1'b0;
        if (host_wr_s) begin
          byte_s    = avs_s1_writedata;
          ack_err_s = 1'b0;
          timeout_s = 1'b0;
          cnt_s     = 32'd0;
          kc_oe_s   = 1'b1;
          state_s   = INHIBIT;
        end else begin
          state_s = IDLE;
        end
      end
      INHIBIT: begin
        if (cnt_r == INHIBIT_CYCLES - 32'd1) begin
          cnt_s   = 32'd0;
          kd_oe_s = 1'b1;
          state_s = RTS;
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      RTS: begin
        if (cnt_r == RTS_CYCLES - 32'd1) begin
          cnt_s     = 32'd0;
          tcnt_s    = 32'd0;
          bit_cnt_s = 4'd0;
          kc_oe_s   = 1'b0;
          state_s   = SEND;
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      SEND: begin
        // Edges 1..8 carry data LSB first, edge 9 parity, edge 10 stop.
        if (kc_fall_s) begin
          bit_cnt_s = bit_cnt_r + 4'd1;
          if (bit_cnt_r < 4'd8) begin
            kd_oe_s = ~byte_r[bit_cnt_r[2:0]];
          end else if (bit_cnt_r == 4'd8) begin
            kd_oe_s = ~odd_parity(byte_r);
          end else begin
            kd_oe_s = 1'b0;
            state_s = ACK;
          end
        end else begin
          bit_cnt_s = bit_cnt_r;
        end
      end
      ACK: begin
        if (kc_fall_s) begin
          ack_err_s = kd_sync_r;
          state_s   = WAIT_IDLE;
        end else begin
          state_s = ACK;
        end
      end
      WAIT_IDLE: begin
        if (kc_sync_r && kd_sync_r) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = WAIT_IDLE;
        end
      end
      default: begin
        kc_oe_s = 1'b0;
        kd_oe_s = 1'b0;
        state_s = IDLE;
      end
    endcase

    // The timeout overrides whatever the bit-level logic decided.
    if ((state_r == SEND) || (state_r == ACK) || (state_r == WAIT_IDLE)) begin
      if (tcnt_r == TIMEOUT_CYCLES - 32'd1) begin
        timeout_s = 1'b1;
        kc_oe_s   = 1'b0;
        kd_oe_s   = 1'b0;
        done_s    = 1'b1;
        state_s   = IDLE;
      end else begin
        tcnt_s = tcnt_r + 32'd1;
      end
    end else begin
      tcnt_s = tcnt_s;
    end

    if (done_s) begin
      irq_s = 1'b1;
    end else if (ctrl_wr_s) begin
      irq_s = 1'b0;
    end else begin
      irq_s = ins_irq0_irq;
    end
  end

  // Datapath, line drivers, interrupt and read-data registers.
  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      coe_kc_oe       <= 1'b0;
      coe_kd_oe       <= 1'b0;
      byte_r          <= 8'd0;
      ack_err_r       <= 1'b0;
      timeout_r       <= 1'b0;
      cnt_r           <= 32'd0;
      tcnt_r          <= 32'd0;
      bit_cnt_r       <= 4'd0;
      ins_irq0_irq    <= 1'b0;
      avs_s1_readdata <= 8'd0;
    end else begin
      coe_kc_oe    <= kc_oe_s;
      coe_kd_oe    <= kd_oe_s;
      byte_r       <= byte_s;
      ack_err_r    <= ack_err_s;
      timeout_r    <= timeout_s;
      cnt_r        <= cnt_s;
      tcnt_r       <= tcnt_s;
      bit_cnt_r    <= bit_cnt_s;
      ins_irq0_irq <= irq_s;
      if (avs_s1_read) begin
        if (avs_s1_address) begin
          avs_s1_readdata <= {7'b0, ins_irq0_irq};
        end else begin
          avs_s1_readdata <= {5'b0, ack_err_r, timeout_r, busy_s};
        end
      end else begin
        avs_s1_readdata <= avs_s1_readdata;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain bus plus a PS/2 device model,
// with expected line bits and status values held in scoreboard queues.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       csi_reset = 1'b1;
  logic       avs_s1_address = 1'b0;
  logic       avs_s1_read = 1'b0;
  logic [7:0] avs_s1_readdata;
  logic       avs_s1_write = 1'b0;
  logic [7:0] avs_s1_writedata = 8'd0;
  logic       ins_irq0_irq;
  logic       coe_kc_oe, coe_kd_oe;
  logic       dev_kc = 1'b1;
  logic       dev_kd = 1'b1;
  wire        kc_line = ~coe_kc_oe & dev_kc;
  wire        kd_line = ~coe_kd_oe & dev_kd;

  int checks = 0;
  int errors = 0;
  logic       bit_q[$];
  logic [7:0] status_q[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES(32'd8),
    .RTS_CYCLES(32'd4),
    .TIMEOUT_CYCLES(32'd200)
  ) dut (
    .csi_clk(clk),
    .csi_reset(csi_reset),
    .avs_s1_address(avs_s1_address),
    .avs_s1_read(avs_s1_read),
    .avs_s1_readdata(avs_s1_readdata),
    .avs_s1_write(avs_s1_write),
    .avs_s1_writedata(avs_s1_writedata),
    .ins_irq0_irq(ins_irq0_irq),
    .coe_kc_in(kc_line),
    .coe_kd_in(kd_line),
    .coe_kc_oe(coe_kc_oe),
    .coe_kd_oe(coe_kd_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic addr, input logic [7:0] data);
    avs_s1_address   = addr;
    avs_s1_writedata = data;
    avs_s1_write     = 1'b1;
    tick();
    avs_s1_write     = 1'b0;
  endtask

  task automatic bus_read(input logic addr, output logic [7:0] data);
    avs_s1_address = addr;
    avs_s1_read    = 1'b1;
    tick();
    avs_s1_read    = 1'b0;
    data           = avs_s1_readdata;
  endtask

  // Expected frame on the kd line: start, data LSB first, odd parity, stop.
  task automatic push_frame(input logic [7:0] b);
    bit_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) bit_q.push_back(b[i]);
    bit_q.push_back(~^b);
    bit_q.push_back(1'b1);
  endtask

  task automatic check_bit(input string tag);
    if (bit_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      check(tag, {31'd0, kd_line}, {31'd0, bit_q.pop_front()});
    end
  endtask

  task automatic check_status(input string tag);
    logic [7:0] rd;
    bus_read(1'b0, rd);
    if (status_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      check(tag, {24'd0, rd}, {24'd0, status_q.pop_front()});
    end
  endtask

  // Device side: wait for clock release, clock out edges, optionally ack.
  task automatic dev_transfer(input bit ack_low, input int stop_edge);
    int n;
    n = 0;
    while (!coe_kc_oe && n < 50) begin tick(); n++; end
    check("inhibit_seen", {31'd0, coe_kc_oe}, 32'd1);
    n = 0;
    while (coe_kc_oe && n < 100) begin tick(); n++; end
    check("clk_released", {31'd0, coe_kc_oe}, 32'd0);
    check_bit("start_bit");
    for (int e = 1; e <= 10; e++) begin
      repeat (6) tick();
      dev_kc = 1'b0;
      if (e == stop_edge) begin
        repeat (3) tick();
        return;
      end
      repeat (6) tick();
      check_bit($sformatf("edge%0d_bit", e));
      dev_kc = 1'b1;
    end
    dev_kd = ack_low ? 1'b0 : 1'b1;
    repeat (6) tick();
    dev_kc = 1'b0;
    repeat (6) tick();
    dev_kc = 1'b1;
    repeat (2) tick();
    dev_kd = 1'b1;
    n = 0;
    while (!ins_irq0_irq && n < 50) begin tick(); n++; end
    check("irq_after_xfer", {31'd0, ins_irq0_irq}, 32'd1);
  endtask

  initial begin
    logic [7:0] rd;
    int active;

    repeat (3) tick();
    csi_reset = 1'b0;
    check("rst_kc_oe", {31'd0, coe_kc_oe}, 32'd0);
    check("rst_kd_oe", {31'd0, coe_kd_oe}, 32'd0);
    check("rst_irq", {31'd0, ins_irq0_irq}, 32'd0);
    check("rst_readdata", {24'd0, avs_s1_readdata}, 32'd0);
    status_q.push_back(8'h00);
    check_status("rst_status");

    // 0xED with device ack
    push_frame(8'hED);
    status_q.push_back(8'h00);
    bus_write(1'b0, 8'hED);
    dev_transfer(1'b1, 0);
    check_status("ed_status");
    bus_read(1'b1, rd);
    check("ed_irq_read", {24'd0, rd}, 32'd1);
    bus_write(1'b1, 8'h00);
    bus_read(1'b1, rd);
    check("irq_cleared", {24'd0, rd}, 32'd0);

    // 0x07 with no ack
    push_frame(8'h07);
    status_q.push_back(8'h04);
    bus_write(1'b0, 8'h07);
    dev_transfer(1'b0, 0);
    check_status("noack_status");
    tick();
    check("readdata_hold", {24'd0, avs_s1_readdata}, 32'h04);
    bus_write(1'b1, 8'h00);

    // 0x55 with a silent device: timeout after 8+4+200 cycles
    status_q.push_back(8'h02);
    bus_write(1'b0, 8'h55);
    active = 0;
    while ((coe_kc_oe || coe_kd_oe) && active < 400) begin active++; tick(); end
    check("timeout_cycles", active, 32'd212);
    check("timeout_irq", {31'd0, ins_irq0_irq}, 32'd1);
    check_status("timeout_status");
    bus_write(1'b1, 8'h00);

    // second write while busy is ignored
    push_frame(8'h11);
    status_q.push_back(8'h01);
    status_q.push_back(8'h00);
    bus_write(1'b0, 8'h11);
    tick();
    bus_write(1'b0, 8'h22);
    check_status("busy_status");
    dev_transfer(1'b1, 0);
    check_status("busy_final_status");
    check("busy_queue_drained", bit_q.size(), 32'd0);

    // reset in the middle of falling edge 5; irq still set from before
    push_frame(8'hA5);
    bus_write(1'b0, 8'hA5);
    dev_transfer(1'b1, 5);
    csi_reset = 1'b1;
    tick();
    csi_reset = 1'b0;
    dev_kc = 1'b1;
    bit_q.delete();
    check("midrst_kc_oe", {31'd0, coe_kc_oe}, 32'd0);
    check("midrst_kd_oe", {31'd0, coe_kd_oe}, 32'd0);
    check("midrst_irq", {31'd0, ins_irq0_irq}, 32'd0);
    repeat (20) tick();
    check("midrst_irq_later", {31'd0, ins_irq0_irq}, 32'd0);
    status_q.push_back(8'h00);
    check_status("midrst_status");

    // timeout completion coincident with an irq-clear write
    status_q.push_back(8'h02);
    bus_write(1'b0, 8'h55);
    repeat (211) tick();
    check("coinc_pre_kc_oe", {31'd0, coe_kc_oe | coe_kd_oe}, 32'd1);
    bus_write(1'b1, 8'h00);
    check("coinc_lines", {31'd0, coe_kc_oe | coe_kd_oe}, 32'd0);
    check("coinc_irq", {31'd0, ins_irq0_irq}, 32'd1);
    check_status("coinc_status");
    bus_write(1'b1, 8'h00);
    check("coinc_irq_clear", {31'd0, ins_irq0_irq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
